// File: rtl/regbank_write_arbiter_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Covers the two-requester grant encoding and the conflict counter limits.
package regbank_pkg;

   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = $clog2(8);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   typedef enum logic {
      GRANT_0 = 1'b0,
      GRANT_1 = 1'b1
   } grant_t;

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Bus bundle between the write sources / reader and the register bank.
// Handshake: a write transfers on a rising clk edge where reqK_valid && reqK_ready;
// the source holds valid/addr/data stable until then, and ready may depend on valid.
interface regbank_write_arbiter_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [15:0]       conflict_cnt;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output rd_addr,
      input  req0_ready, req1_ready, rd_data, conflict_cnt
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  rd_addr,
      output req0_ready, req1_ready, rd_data, conflict_cnt
   );
endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, last_grant state moves
// only when a grant is issued (every grant is an accepted handshake).
module rr_arbiter2
   import regbank_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o,
   output grant_t     last_grant_o
);

   grant_t last_grant_q;

   // Grants are suppressed while reset is held so no handshake can occur.
   always_comb begin
      grant_o = 2'b00;
      if (rst_n) begin
         case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_grant_q == GRANT_1) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= GRANT_1;
      end else if (|grant_o) begin
         last_grant_q <= grant_o[1] ? GRANT_1 : GRANT_0;
      end
   end

   assign last_grant_o = last_grant_q;

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register bank with a shared, round-robin arbitrated write port, a one-entry
// commit stage and a forwarding combinational read port.
module regbank_write_arbiter #(
   parameter int NUM_REGS   = 8,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = $clog2(NUM_REGS),
   parameter bit PROTECT_R0 = 1'b1
) (
   input  logic                    clk,
   input  logic                    R,
   regbank_write_arbiter_if.slave  bus,
   output logic                    dbg_last_grant_o
);
   import regbank_pkg::*;

   logic [1:0]        valid;
   logic [1:0]        grant;
   grant_t            last_grant;
   logic              accept;
   logic              drop;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   logic              pipe_valid_q, pipe_valid_d;
   logic [ADDR_W-1:0] pipe_addr_q,  pipe_addr_d;
   logic [DATA_W-1:0] pipe_data_q,  pipe_data_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic [DATA_W-1:0] bank_q [NUM_REGS];

   assign valid = {bus.req1_valid, bus.req0_valid};

   rr_arbiter2 u_arb (
      .clk          (clk),
      .rst_n        (R),
      .valid_i      (valid),
      .grant_o      (grant),
      .last_grant_o (last_grant)
   );

   assign bus.req0_ready   = grant[0];
   assign bus.req1_ready   = grant[1];
   assign dbg_last_grant_o = last_grant;

   // A write to r0 on a protected bank still handshakes but never enters the pipe.
   always_comb begin
      sel_addr     = grant[1] ? bus.req1_addr : bus.req0_addr;
      sel_data     = grant[1] ? bus.req1_data : bus.req0_data;
      accept       = |grant;
      drop         = PROTECT_R0 && (sel_addr == '0);
      pipe_valid_d = accept && !drop;
      pipe_addr_d  = pipe_valid_d ? sel_addr : pipe_addr_q;
      pipe_data_d  = pipe_valid_d ? sel_data : pipe_data_q;
      cnt_d        = cnt_q;
      if (&valid && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         pipe_valid_q <= 1'b0;
         pipe_addr_q  <= '0;
         pipe_data_q  <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         pipe_valid_q <= pipe_valid_d;
         pipe_addr_q  <= pipe_addr_d;
         pipe_data_q  <= pipe_data_d;
         cnt_q        <= cnt_d;
         if (pipe_valid_q) begin
            bank_q[pipe_addr_q] <= pipe_data_q;
         end
      end
   end

   // The pipe always holds the youngest accepted write, so it takes priority.
   always_comb begin
      if (PROTECT_R0 && (bus.rd_addr == '0)) begin
         bus.rd_data = '0;
      end else if (pipe_valid_q && (pipe_addr_q == bus.rd_addr)) begin
         bus.rd_data = pipe_data_q;
      end else begin
         bus.rd_data = bank_q[bus.rd_addr];
      end
   end

   assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter: directed scenarios plus a
// randomized run checked against an architectural register-file model.
module tb_regbank_write_arbiter;
   import regbank_pkg::*;

   localparam int NR = 8;
   localparam int AW = 3;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic R;
   logic dbg_last_grant;
   always #5 clk = ~clk;

   regbank_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   regbank_write_arbiter #(
      .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .PROTECT_R0(1'b1)
   ) dut (
      .clk              (clk),
      .R                (R),
      .bus              (bus.slave),
      .dbg_last_grant_o (dbg_last_grant)
   );

   // Architectural model: the value each register shows to a reader.
   logic [DW-1:0] mem_m [NR];
   int last_m;
   int cnt_m;
   int pass_cnt = 0;
   int chk_cnt  = 0;

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) mem_m[i] = '0;
      last_m = 1;
      cnt_m  = 0;
   endfunction

   function automatic logic [1:0] model_grant(input logic v0, input logic v1);
      if (v0 && v1) return (last_m == 1) ? 2'b01 : 2'b10;
      return {v1, v0};
   endfunction

   task automatic set_idle();
      bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
   endtask

   task automatic apply_reset();
      R = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      R = 1'b1;
      model_reset();
   endtask

   // One bus cycle: drive at negedge, sample readys, advance past the edge, update model.
   task automatic drive_cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              output logic [1:0] obs, output logic [1:0] exp);
      int g;
      logic [AW-1:0] wa;
      @(negedge clk);
      bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
      #1;
      obs = {bus.req1_ready, bus.req0_ready};
      exp = model_grant(v0, v1);
      @(posedge clk);
      #1;
      if (exp != 2'b00) begin
         g = exp[1] ? 1 : 0;
         last_m = g;
         wa = g ? a1 : a0;
         if (wa != '0) mem_m[wa] = g ? d1 : d0;
      end
      if (v0 && v1 && cnt_m < 65535) cnt_m++;
   endtask

   task automatic idle_cycle();
      logic [1:0] o, e;
      drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, o, e);
   endtask

   task automatic sample_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      bus.rd_addr = a;
      #1;
      d = bus.rd_data;
   endtask

   task automatic test_reset();
      logic [DW-1:0] d;
      R = 1'b0;
      bus.rd_addr = '0;
      bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 32'h5;
      bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 32'h6;
      #3;
      chk_cnt++;
      if (bus.req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b expected 0", bus.req0_ready);
      else pass_cnt++;
      chk_cnt++;
      if (bus.req1_ready !== 1'b0) $display("FAIL reset_req1_ready: got %b expected 0", bus.req1_ready);
      else pass_cnt++;
      set_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      R = 1'b1;
      model_reset();
      #1;
      chk_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
         $display("FAIL idle_readys: got %b expected 00", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      chk_cnt++;
      if (bus.conflict_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.conflict_cnt);
      else pass_cnt++;
      chk_cnt++;
      if (dbg_last_grant !== 1'b1) $display("FAIL reset_last_grant: got %b expected 1", dbg_last_grant);
      else pass_cnt++;
      for (int i = 0; i < NR; i++) begin
         sample_read(AW'(i), d);
         chk_cnt++;
         if (d !== '0) $display("FAIL reset_rd[%0d]: got %h expected 0", i, d);
         else pass_cnt++;
      end
   endtask

   task automatic test_single();
      logic [1:0] o, e;
      logic [DW-1:0] d;
      drive_cycle(1'b1, 3'd3, 32'hAAAAAAAA, 1'b0, '0, '0, o, e);
      chk_cnt++;
      if (o !== 2'b01) $display("FAIL single_ready: got %b expected 01", o);
      else pass_cnt++;
      sample_read(3'd3, d);
      chk_cnt++;
      if (d !== 32'hAAAAAAAA) $display("FAIL single_fwd: got %h expected aaaaaaaa", d);
      else pass_cnt++;
      idle_cycle();
      idle_cycle();
      sample_read(3'd3, d);
      chk_cnt++;
      if (d !== 32'hAAAAAAAA) $display("FAIL single_bank: got %h expected aaaaaaaa", d);
      else pass_cnt++;
   endtask

   task automatic test_conflict_rr();
      logic [1:0] o, e;
      logic [DW-1:0] d;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 3'd1, 32'h1, 1'b1, 3'd2, 32'h2, o, e);
         chk_cnt++;
         if (o !== ((i % 2 == 0) ? 2'b01 : 2'b10) || o !== e)
            $display("FAIL conflict_grant[%0d]: got %b expected %b", i, o, e);
         else pass_cnt++;
      end
      set_idle();
      #1;
      chk_cnt++;
      if (bus.conflict_cnt !== 16'd4) $display("FAIL conflict_cnt: got %0d expected 4", bus.conflict_cnt);
      else pass_cnt++;
      idle_cycle();
      idle_cycle();
      sample_read(3'd1, d);
      chk_cnt++;
      if (d !== 32'h1) $display("FAIL conflict_r1: got %h expected 1", d);
      else pass_cnt++;
      sample_read(3'd2, d);
      chk_cnt++;
      if (d !== 32'h2) $display("FAIL conflict_r2: got %h expected 2", d);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] o, e;
      logic [DW-1:0] d;
      drive_cycle(1'b1, 3'd5, 32'h1F2E3D4C, 1'b0, '0, '0, o, e);
      sample_read(3'd5, d);
      chk_cnt++;
      if (d !== 32'h1F2E3D4C) $display("FAIL b2b_first: got %h expected 1f2e3d4c", d);
      else pass_cnt++;
      drive_cycle(1'b1, 3'd5, 32'h0000FFFF, 1'b0, '0, '0, o, e);
      sample_read(3'd5, d);
      chk_cnt++;
      if (d !== 32'h0000FFFF) $display("FAIL b2b_second: got %h expected 0000ffff", d);
      else pass_cnt++;
      idle_cycle();
      idle_cycle();
      sample_read(3'd5, d);
      chk_cnt++;
      if (d !== mem_m[5] || d !== 32'h0000FFFF) $display("FAIL b2b_final: got %h expected 0000ffff", d);
      else pass_cnt++;
   endtask

   task automatic test_r0_protect();
      logic [1:0] o, e;
      logic [DW-1:0] d;
      drive_cycle(1'b0, '0, '0, 1'b1, 3'd0, 32'hDEADBEEF, o, e);
      chk_cnt++;
      if (o !== 2'b10) $display("FAIL r0_ready: got %b expected 10", o);
      else pass_cnt++;
      sample_read(3'd0, d);
      chk_cnt++;
      if (d !== '0) $display("FAIL r0_fwd: got %h expected 0", d);
      else pass_cnt++;
      drive_cycle(1'b1, 3'd6, 32'h66, 1'b1, 3'd7, 32'h77, o, e);
      chk_cnt++;
      if (o !== 2'b01) $display("FAIL r0_next_grant: got %b expected 01", o);
      else pass_cnt++;
      idle_cycle();
      sample_read(3'd0, d);
      chk_cnt++;
      if (d !== '0) $display("FAIL r0_bank: got %h expected 0", d);
      else pass_cnt++;
   endtask

   task automatic test_random();
      wr_req_t pend [2];
      logic pv [2];
      logic [1:0] o, e;
      logic [DW-1:0] d;
      logic [AW-1:0] ra;
      int errs = 0;
      pv[0] = 1'b0; pv[1] = 1'b0;
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pv[k] && $urandom_range(0, 9) < 6) begin
               pv[k] = 1'b1;
               pend[k].addr = AW'($urandom_range(0, NR - 1));
               pend[k].data = $urandom;
            end
         end
         drive_cycle(pv[0], pend[0].addr, pend[0].data, pv[1], pend[1].addr, pend[1].data, o, e);
         chk_cnt++;
         if (o !== e) begin
            $display("FAIL rand_grant[%0d]: got %b expected %b", c, o, e);
            errs++;
         end else pass_cnt++;
         if (e[0]) pv[0] = 1'b0;
         if (e[1]) pv[1] = 1'b0;
         ra = AW'($urandom_range(0, NR - 1));
         sample_read(ra, d);
         chk_cnt++;
         if (d !== mem_m[ra]) begin
            $display("FAIL rand_rd[%0d] addr %0d: got %h expected %h", c, ra, d, mem_m[ra]);
            errs++;
         end else pass_cnt++;
      end
      set_idle();
      #1;
      chk_cnt++;
      if (bus.conflict_cnt !== 16'(cnt_m))
         $display("FAIL rand_cnt: got %0d expected %0d", bus.conflict_cnt, cnt_m);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [1:0] o, e;
      logic [DW-1:0] d;
      drive_cycle(1'b1, 3'd4, 32'h12345678, 1'b0, '0, '0, o, e);
      set_idle();
      #2;
      R = 1'b0;
      #1;
      sample_read(3'd4, d);
      chk_cnt++;
      if (d !== '0) $display("FAIL midrst_rd_during: got %h expected 0", d);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      R = 1'b1;
      model_reset();
      #1;
      chk_cnt++;
      if (bus.conflict_cnt !== 16'd0) $display("FAIL midrst_cnt: got %0d expected 0", bus.conflict_cnt);
      else pass_cnt++;
      idle_cycle();
      sample_read(3'd4, d);
      chk_cnt++;
      if (d !== '0) $display("FAIL midrst_rd_after: got %h expected 0", d);
      else pass_cnt++;
   endtask

   initial begin
      R = 1'b0;
      set_idle();
      bus.rd_addr = '0;
      model_reset();
      test_reset();
      test_single();
      test_conflict_rr();
      test_back_to_back();
      test_r0_protect();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
Owns a bank of NUM_REGS 32-bit registers and shares its single write port between two requesters using valid/ready handshakes with round-robin arbitration. Accepted writes pass through a one-entry commit pipeline stage before reaching the bank. A combinational read port forwards in-flight writes, so readers never see stale data. Sits between the datapath write sources (e.g. ALU writeback and load unit) and the register storage.

Parameters:
NUM_REGS, 8, number of 32-bit registers in the bank (power of 2, >= 2)
DATA_W, 32, register width
ADDR_W, $clog2(NUM_REGS), register address width
PROTECT_R0, 1, when 1 register 0 is hard-wired to zero and writes to it are dropped

Ports:
clk  input  1  clock, all state updates on rising edge
R  input  1  asynchronous reset, active-low (0 = reset)
req0_valid  input  1  requester 0 write request
req0_addr  input  ADDR_W  requester 0 target register
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 granted this cycle
req1_valid  input  1  requester 1 write request
req1_addr  input  ADDR_W  requester 1 target register
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 granted this cycle
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data, combinational
conflict_cnt  output  16  saturating count of cycles with both valids high

Behaviour:
- Reset (R=0, asynchronous): all bank registers 0, pipe_valid=0, pipe_addr=0, pipe_data=0, last_grant=1 (requester 0 wins the first conflict), conflict_cnt=0. req0_ready and req1_ready are forced to 0 while R=0. rd_data reflects the cleared bank (0).
- Grant (combinational): exactly one of reqK_ready is high when at least one valid is high; neither when both valids are low.
  - Only one valid high: that requester is granted.
  - Both valids high: grant the requester not equal to last_grant.
- Handshake: a write is accepted on a rising edge where reqK_valid && reqK_ready. Requesters hold valid/addr/data stable until accepted; the arbiter does not check this.
- last_grant updates to the granted index only on an accepted write. It holds otherwise.
- Pipeline: the accepted write loads into pipe (pipe_valid=1, pipe_addr, pipe_data) at handshake edge N. At edge N+1, bank[pipe_addr] <= pipe_data when pipe_valid. The pipe reloads with the next accepted write or clears to pipe_valid=0. Throughput is one write per cycle. Write-to-bank latency is 2 edges.
- Read: rd_data = pipe_data if pipe_valid && pipe_addr==rd_addr, else bank[rd_addr]. A write is therefore readable from the cycle after its handshake.
- PROTECT_R0=1:
  - A write to address 0 still completes its handshake, consumes its grant and updates last_grant.
  - It never sets pipe_valid and never modifies bank[0].
  - rd_addr=0 always returns 0.
- Back-to-back writes to the same address: commit order equals acceptance order, so the last write wins. Forwarding always returns the youngest value.
- conflict_cnt increments on every edge where req0_valid && req1_valid (R high). It saturates at 16'hFFFF.
- Reset mid-operation drops an in-flight pipe write and clears the bank. No partial write is permitted.

Decomposition:
- Shared package regbank_pkg holds:
  - NUM_REQ=2, CNT_W=16, CNT_MAX=16'hFFFF
  - typedef wr_req_t {addr, data} (parameterized widths via package constants DATA_W=32)
  - enum grant_t {GRANT_0, GRANT_1}
- One natural sub-module: rr_arbiter2, a two-input round-robin grant with last_grant state, instantiated once. The bank, pipe and forwarding logic stay in the top.

Test Plan:
- Reset then idle: R low 2 cycles, release; rd_addr 0..7 -> rd_data=0, both readys 0, conflict_cnt=0.
- Single requester: req0 writes addr 3 = 32'hAAAAAAAA. Required response:
  - req0_ready=1 in the same cycle.
  - rd_addr=3 returns 32'hAAAAAAAA from the next cycle via forwarding, and persists after pipe_valid drops.
- Conflict round-robin: both valid for 4 cycles, req0 addr 1 data 32'h1, req1 addr 2 data 32'h2 (held). Required response:
  - Grants go 0,1,0,1.
  - conflict_cnt=4.
  - Final reads give r1=1 and r2=2.
- Same-address back-to-back: req0 writes addr 5 = 32'h1F2E3D4C, then addr 5 = 32'h0000FFFF on the next cycle -> rd_addr=5 returns 32'h1F2E3D4C, then 32'h0000FFFF; the final bank value is 32'h0000FFFF.
- R0 protection: req1 writes addr 0 = 32'hDEADBEEF -> req1_ready=1, rd_addr=0 stays 0, and the next conflict grants req0.
- Reset mid-operation: R asserted async one cycle after a handshake on addr 4 = 32'h12345678 -> rd_addr=4 returns 0 after release, pipe empty, counter 0.
